// File: rtl/viterbi_codec.sv
// Rate-1/2, K=3 convolutional codec (generators 7/5 octal).
// The encoder and the hard-decision Viterbi decoder are independent blocks
// sharing one clock and reset. The decoder keeps its survivors by register
// exchange and releases each decision 15 accepted symbols after it arrives.

module encoder (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable_i,
  input  logic       d_in,
  output logic       valid_o,
  output logic [1:0] d_out
);

  // state_q = {s1, s2}; s1 is the most recently accepted bit
  logic [1:0] state_q, state_d;
  logic [1:0] sym_q, sym_d;
  logic       valid_q, valid_d;

  // Next-state / symbol generation; everything holds when the input is not valid
  always_comb begin
    state_d = state_q;
    sym_d   = sym_q;
    valid_d = 1'b0;
    if (enable_i) begin
      sym_d   = {d_in ^ state_q[1] ^ state_q[0], d_in ^ state_q[0]};
      state_d = {d_in, state_q[1]};
      valid_d = 1'b1;
    end
  end

  // Encoder registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= 2'b00;
      sym_q   <= 2'b00;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sym_q   <= sym_d;
      valid_q <= valid_d;
    end
  end

  assign d_out   = sym_q;
  assign valid_o = valid_q;

endmodule

module decoder (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [1:0] d_in,
  output logic       d_out
);

  localparam int NSTATES = 4;
  localparam int DEPTH   = 16;

  logic [7:0]       metric_q [NSTATES];
  logic [7:0]       metric_d [NSTATES];
  logic [DEPTH-1:0] path_q   [NSTATES];
  logic [DEPTH-1:0] path_d   [NSTATES];
  logic             d_out_q, d_out_d;

  // ACS scratch
  logic [7:0]       acs  [NSTATES];
  logic [DEPTH-1:0] surv [NSTATES];
  logic [1:0]       st, pr0, pr1, best;
  logic [7:0]       cand0, cand1;
  logic             norm;

  // Code symbol emitted when leaving state s = {s1, s2} with input u
  function automatic logic [1:0] expected_sym(input logic u, input logic [1:0] s);
    return {u ^ s[1] ^ s[0], u ^ s[0]};
  endfunction

  // Hamming distance between two 2-bit symbols (0..2)
  function automatic logic [1:0] branch_metric(input logic [1:0] e, input logic [1:0] r);
    logic [1:0] x;
    x = e ^ r;
    return {1'b0, x[1]} + {1'b0, x[0]};
  endfunction

  // Metric accumulate clamped at 255 so a metric can never wrap round
  function automatic logic [7:0] sat_add(input logic [7:0] m, input logic [1:0] b);
    logic [8:0] sum;
    sum = {1'b0, m} + {7'b0, b};
    return sum[8] ? 8'hFF : sum[7:0];
  endfunction

  // Add-compare-select, normalization, survivor exchange and best-state decision
  always_comb begin
    st      = 2'b00;
    pr0     = 2'b00;
    pr1     = 2'b00;
    cand0   = 8'd0;
    cand1   = 8'd0;
    norm    = 1'b1;
    best    = 2'd0;
    d_out_d = d_out_q;
    for (int i = 0; i < NSTATES; i++) begin
      acs[i]      = 8'd0;
      surv[i]     = '0;
      metric_d[i] = metric_q[i];
      path_d[i]   = path_q[i];
    end

    // state {u,a} is reached from {a,0} and {a,1}; input bit is u
    for (int ns = 0; ns < NSTATES; ns++) begin
      st    = 2'(ns);
      pr0   = {st[0], 1'b0};
      pr1   = {st[0], 1'b1};
      cand0 = sat_add(metric_q[pr0], branch_metric(expected_sym(st[1], pr0), d_in));
      cand1 = sat_add(metric_q[pr1], branch_metric(expected_sym(st[1], pr1), d_in));
      // ties favour the predecessor whose s2 is 0
      if (cand1 < cand0) begin
        acs[ns]  = cand1;
        surv[ns] = {path_q[pr1][DEPTH-2:0], st[1]};
      end else begin
        acs[ns]  = cand0;
        surv[ns] = {path_q[pr0][DEPTH-2:0], st[1]};
      end
      norm = norm & acs[ns][7];
    end

    if (enable) begin
      // when every metric has bit 7 set, dropping that bit subtracts 128 from all
      for (int ns = 0; ns < NSTATES; ns++) begin
        metric_d[ns] = norm ? {1'b0, acs[ns][6:0]} : acs[ns];
        path_d[ns]   = surv[ns];
      end
      // lowest index wins among equal metrics
      for (int ns = 1; ns < NSTATES; ns++) begin
        if (metric_d[ns] < metric_d[best]) best = 2'(ns);
      end
      d_out_d = surv[best][DEPTH-1];
    end
  end

  // Decoder registers; reset biases the trellis towards the all-zero start state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NSTATES; i++) begin
        metric_q[i] <= (i == 0) ? 8'd0 : 8'd64;
        path_q[i]   <= '0;
      end
      d_out_q <= 1'b0;
    end else begin
      for (int i = 0; i < NSTATES; i++) begin
        metric_q[i] <= metric_d[i];
        path_q[i]   <= path_d[i];
      end
      d_out_q <= d_out_d;
    end
  end

  assign d_out = d_out_q;

endmodule

module viterbi_codec (
  input  logic       clk,
  input  logic       rst,
  input  logic       enc_enable_i,
  input  logic       enc_d_i,
  output logic       enc_valid_o,
  output logic [1:0] enc_d_o,
  input  logic       dec_enable_i,
  input  logic [1:0] dec_d_i,
  output logic       dec_d_o
);

  encoder u_enc (
    .clk      (clk),
    .rst      (rst),
    .enable_i (enc_enable_i),
    .d_in     (enc_d_i),
    .valid_o  (enc_valid_o),
    .d_out    (enc_d_o)
  );

  decoder u_dec (
    .clk    (clk),
    .rst    (rst),
    .enable (dec_enable_i),
    .d_in   (dec_d_i),
    .d_out  (dec_d_o)
  );

endmodule

// File: tb/tb_viterbi_codec.sv
// Directed bench for viterbi_codec: encoder vectors, decoder loopback with
// and without channel errors, long all-ones run, metric normalization and
// asynchronous reset.

module tb_viterbi_codec;

  logic       clk;
  logic       rst;
  logic       enc_enable_i;
  logic       enc_d_i;
  logic       enc_valid_o;
  logic [1:0] enc_d_o;
  logic       dec_enable_i;
  logic [1:0] dec_d_i;
  logic       dec_d_o;

  int n_checks;
  int n_pass;

  logic [1:0]  model_st;
  logic [15:0] lfsr;
  logic        hist [0:1023];

  viterbi_codec dut (
    .clk          (clk),
    .rst          (rst),
    .enc_enable_i (enc_enable_i),
    .enc_d_i      (enc_d_i),
    .enc_valid_o  (enc_valid_o),
    .enc_d_o      (enc_d_o),
    .dec_enable_i (dec_enable_i),
    .dec_d_i      (dec_d_i),
    .dec_d_o      (dec_d_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] code_sym(input logic b, input logic [1:0] s);
    return {b ^ s[1] ^ s[0], b ^ s[0]};
  endfunction

  function automatic logic next_bit();
    logic b;
    b    = lfsr[0];
    lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    return b;
  endfunction

  task automatic idle_inputs();
    enc_enable_i = 1'b0;
    enc_d_i      = 1'b0;
    dec_enable_i = 1'b0;
    dec_d_i      = 2'b00;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
    model_st = 2'b00;
  endtask

  // Drives n bits through the encoder and their (optionally corrupted) symbols
  // into the decoder. mode 0: LFSR bits, mode 1: all ones.
  task automatic run_stream(input string name, input int n, input int mode,
                            input int err_period, input int gap_period,
                            input int check_from);
    logic       b;
    logic [1:0] sym;
    logic [1:0] rx;
    for (int j = 0; j < n; j++) begin
      if (gap_period > 0 && j > 0 && (j % gap_period) == 0) begin
        idle_inputs();
        step();
        n_checks++;
        if (enc_valid_o !== 1'b0)
          $display("FAIL %s gap valid_o j=%0d got %b want 0", name, j, enc_valid_o);
        else n_pass++;
        if (j - 1 >= 15 && j - 1 >= check_from) begin
          n_checks++;
          if (dec_d_o !== hist[j-16])
            $display("FAIL %s gap hold j=%0d got %b want %b", name, j, dec_d_o, hist[j-16]);
          else n_pass++;
        end
      end
      b       = (mode == 1) ? 1'b1 : next_bit();
      hist[j] = b;
      sym     = code_sym(b, model_st);
      model_st = {b, model_st[1]};
      rx = sym;
      if (err_period > 0 && (j % err_period) == 10)
        rx = sym ^ (((j / err_period) % 2) ? 2'b10 : 2'b01);
      enc_enable_i = 1'b1;
      enc_d_i      = b;
      dec_enable_i = 1'b1;
      dec_d_i      = rx;
      step();
      n_checks++;
      if (enc_d_o !== sym || enc_valid_o !== 1'b1)
        $display("FAIL %s enc j=%0d got %b/%b want %b/1", name, j, enc_d_o, enc_valid_o, sym);
      else n_pass++;
      if (j >= 15 && j >= check_from) begin
        n_checks++;
        if (dec_d_o !== hist[j-15])
          $display("FAIL %s dec j=%0d got %b want %b", name, j, dec_d_o, hist[j-15]);
        else n_pass++;
      end
    end
    idle_inputs();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b0;
    step();
    step();
    n_checks++;
    if (enc_d_o !== 2'b00) $display("FAIL reset enc_d_o got %b want 00", enc_d_o);
    else n_pass++;
    n_checks++;
    if (enc_valid_o !== 1'b0) $display("FAIL reset enc_valid_o got %b want 0", enc_valid_o);
    else n_pass++;
    n_checks++;
    if (dec_d_o !== 1'b0) $display("FAIL reset dec_d_o got %b want 0", dec_d_o);
    else n_pass++;
    rst = 1'b1;
    model_st = 2'b00;
  endtask

  task automatic test_encoder_impulse();
    logic       bits [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    logic [1:0] exp  [4] = '{2'b11, 2'b10, 2'b11, 2'b00};
    for (int i = 0; i < 4; i++) begin
      enc_enable_i = 1'b1;
      enc_d_i      = bits[i];
      step();
      n_checks++;
      if (enc_d_o !== exp[i] || enc_valid_o !== 1'b1)
        $display("FAIL impulse %0d got %b/%b want %b/1", i, enc_d_o, enc_valid_o, exp[i]);
      else n_pass++;
    end
    idle_inputs();
  endtask

  // state is 00 here; a bit presented during the gap must be ignored
  task automatic test_encoder_gap();
    enc_enable_i = 1'b1; enc_d_i = 1'b1;
    step();
    n_checks++;
    if (enc_d_o !== 2'b11 || enc_valid_o !== 1'b1)
      $display("FAIL gap first got %b/%b want 11/1", enc_d_o, enc_valid_o);
    else n_pass++;
    enc_enable_i = 1'b0; enc_d_i = 1'b1;
    step();
    n_checks++;
    if (enc_d_o !== 2'b11 || enc_valid_o !== 1'b0)
      $display("FAIL gap hold got %b/%b want 11/0", enc_d_o, enc_valid_o);
    else n_pass++;
    enc_enable_i = 1'b1; enc_d_i = 1'b1;
    step();
    n_checks++;
    if (enc_d_o !== 2'b01 || enc_valid_o !== 1'b1)
      $display("FAIL gap resume got %b/%b want 01/1", enc_d_o, enc_valid_o);
    else n_pass++;
    idle_inputs();
  endtask

  task automatic test_loopback_clean();
    apply_reset();
    lfsr = 16'hACE1;
    run_stream("clean", 256, 0, 0, 50, 0);
  endtask

  task automatic test_single_errors();
    apply_reset();
    lfsr = 16'h1D2B;
    run_stream("errors", 256, 0, 32, 0, 0);
  endtask

  task automatic test_long_ones();
    apply_reset();
    run_stream("ones", 320, 1, 0, 0, 0);
  endtask

  // Uncorrelated symbols drive every metric upward; the smallest must always
  // stay below 128, then a clean stream must be recovered after resync.
  task automatic test_normalization();
    int viol;
    logic [7:0] mn;
    apply_reset();
    lfsr = 16'h5EED;
    viol = 0;
    for (int j = 0; j < 2000; j++) begin
      dec_enable_i = 1'b1;
      dec_d_i      = {next_bit(), next_bit()};
      step();
      mn = dut.u_dec.metric_q[0];
      for (int i = 1; i < 4; i++)
        if (dut.u_dec.metric_q[i] < mn) mn = dut.u_dec.metric_q[i];
      if (mn >= 8'd128) viol++;
    end
    n_checks++;
    if (viol != 0) $display("FAIL norm min_metric violations got %0d want 0", viol);
    else n_pass++;
    lfsr = 16'h3C3C;
    run_stream("resync", 200, 0, 0, 0, 60);
  endtask

  task automatic test_async_reset();
    apply_reset();
    run_stream("pre_rst", 20, 1, 0, 0, 0);
    enc_enable_i = 1'b1; enc_d_i = 1'b1; dec_enable_i = 1'b1; dec_d_i = 2'b10;
    #3;
    rst = 1'b0;
    #1;
    n_checks++;
    if (enc_d_o !== 2'b00 || enc_valid_o !== 1'b0)
      $display("FAIL async enc got %b/%b want 00/0", enc_d_o, enc_valid_o);
    else n_pass++;
    n_checks++;
    if (dec_d_o !== 1'b0) $display("FAIL async dec got %b want 0", dec_d_o);
    else n_pass++;
    idle_inputs();
    step();
    #2;
    rst = 1'b1;
    model_st = 2'b00;
    step();
    lfsr = 16'h7A11;
    run_stream("post_rst", 64, 0, 0, 0, 0);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    model_st = 2'b00;
    lfsr     = 16'h0001;
    rst      = 1'b0;
    idle_inputs();
    test_reset();
    test_encoder_impulse();
    test_encoder_gap();
    test_loopback_clean();
    test_single_errors();
    test_long_ones();
    test_normalization();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
